// File: rtl/alu_seq.sv
// Sequential ALU for the EX stage: single-cycle logic/arith/shift ops plus a
// WIDTH-cycle shift-add MULTU. All outputs are registered; start/finished handshake.
module alu_seq #(
  parameter int unsigned WIDTH               = 32,
  parameter int unsigned SHAMT_W             = $clog2(WIDTH),
  parameter int unsigned CONTROL_SIGNAL_SIZE = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic [WIDTH-1:0]               input_a,
  input  logic [WIDTH-1:0]               input_b,
  input  logic [CONTROL_SIGNAL_SIZE-1:0] control,
  output logic                           busy,
  output logic                           finished,
  output logic [WIDTH-1:0]               result,
  output logic [WIDTH-1:0]               result_hi,
  output logic                           zero,
  output logic                           cout,
  output logic                           err_overflow,
  output logic                           err_invalid_control
);

  localparam int unsigned Msb  = WIDTH - 1;
  localparam int unsigned CntW = $clog2(WIDTH);

  localparam logic [CONTROL_SIGNAL_SIZE-1:0] OpAnd   = 'h0;
  localparam logic [CONTROL_SIGNAL_SIZE-1:0] OpOr    = 'h1;
  localparam logic [CONTROL_SIGNAL_SIZE-1:0] OpAdd   = 'h2;
  localparam logic [CONTROL_SIGNAL_SIZE-1:0] OpAddu  = 'h3;
  localparam logic [CONTROL_SIGNAL_SIZE-1:0] OpSltu  = 'h4;
  localparam logic [CONTROL_SIGNAL_SIZE-1:0] OpSub   = 'h6;
  localparam logic [CONTROL_SIGNAL_SIZE-1:0] OpSlt   = 'h7;
  localparam logic [CONTROL_SIGNAL_SIZE-1:0] OpSll   = 'h8;
  localparam logic [CONTROL_SIGNAL_SIZE-1:0] OpSrl   = 'h9;
  localparam logic [CONTROL_SIGNAL_SIZE-1:0] OpSra   = 'hA;
  localparam logic [CONTROL_SIGNAL_SIZE-1:0] OpNor   = 'hC;
  localparam logic [CONTROL_SIGNAL_SIZE-1:0] OpMultu = 'hD;

  typedef enum logic [1:0] {StIdle, StExec, StMul, StDone} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0]               a_q, b_q;
  logic [CONTROL_SIGNAL_SIZE-1:0] ctrl_q;
  logic [2*WIDTH-1:0]             prod_q, prod_step;
  logic [CntW-1:0]                cnt_q;

  logic [WIDTH-1:0] result_q, result_hi_q;
  logic             zero_q, cout_q, ovf_q, inv_q, finished_q, busy_q;

  logic [WIDTH:0]   sum_add, sum_sub, mul_sum;
  logic [WIDTH-1:0] exec_res;
  logic             exec_cout, exec_ovf, exec_inv;
  logic [SHAMT_W-1:0] shamt;

  assign busy                = busy_q;
  assign finished            = finished_q;
  assign result              = result_q;
  assign result_hi           = result_hi_q;
  assign zero                = zero_q;
  assign cout                = cout_q;
  assign err_overflow        = ovf_q;
  assign err_invalid_control = inv_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = (control == OpMultu) ? StMul : StExec;
        end
      end
      StExec: state_d = StIdle;
      StMul: begin
        if (cnt_q == '0) begin
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    shamt     = b_q[SHAMT_W-1:0];
    sum_add   = {1'b0, a_q} + {1'b0, b_q};
    sum_sub   = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};
    exec_res  = '0;
    exec_cout = 1'b0;
    exec_ovf  = 1'b0;
    exec_inv  = 1'b0;
    case (ctrl_q)
      OpAnd: exec_res = a_q & b_q;
      OpOr:  exec_res = a_q | b_q;
      OpNor: exec_res = ~(a_q | b_q);
      OpAdd: begin
        exec_res  = sum_add[WIDTH-1:0];
        exec_cout = sum_add[WIDTH];
        exec_ovf  = (a_q[Msb] == b_q[Msb]) && (sum_add[Msb] != a_q[Msb]);
      end
      OpAddu: begin
        exec_res  = sum_add[WIDTH-1:0];
        exec_cout = sum_add[WIDTH];
        exec_ovf  = sum_add[WIDTH];
      end
      OpSub: begin
        exec_res  = sum_sub[WIDTH-1:0];
        exec_cout = sum_sub[WIDTH];
        exec_ovf  = (a_q[Msb] != b_q[Msb]) && (sum_sub[Msb] != a_q[Msb]);
      end
      OpSlt:  exec_res = {{(WIDTH-1){1'b0}}, $signed(a_q) < $signed(b_q)};
      OpSltu: exec_res = {{(WIDTH-1){1'b0}}, a_q < b_q};
      OpSll:  exec_res = a_q << shamt;
      OpSrl:  exec_res = a_q >> shamt;
      OpSra:  exec_res = $unsigned($signed(a_q) >>> shamt);
      default: exec_inv = 1'b1;
    endcase
  end

  // Shift-add step: add multiplicand into the high half when the multiplier LSB is set.
  always_comb begin
    mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    prod_step = {mul_sum, prod_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_q         <= '0;
      b_q         <= '0;
      ctrl_q      <= '0;
      prod_q      <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b1;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      inv_q       <= 1'b0;
      finished_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      finished_q <= 1'b0;
      busy_q     <= (state_d != StIdle);
      case (state_q)
        StIdle: begin
          if (start) begin
            a_q    <= input_a;
            b_q    <= input_b;
            ctrl_q <= control;
            prod_q <= {{WIDTH{1'b0}}, input_b};
            cnt_q  <= CntW'(WIDTH - 1);
          end
        end
        StExec: begin
          result_q    <= exec_res;
          result_hi_q <= '0;
          zero_q      <= (exec_res == '0);
          cout_q      <= exec_cout;
          ovf_q       <= exec_ovf;
          inv_q       <= exec_inv;
          finished_q  <= 1'b1;
        end
        StMul: begin
          prod_q <= prod_step;
          cnt_q  <= cnt_q - 1'b1;
        end
        StDone: begin
          result_q    <= prod_q[WIDTH-1:0];
          result_hi_q <= prod_q[2*WIDTH-1:WIDTH];
          zero_q      <= (prod_q[WIDTH-1:0] == '0);
          cout_q      <= 1'b0;
          ovf_q       <= 1'b0;
          inv_q       <= 1'b0;
          finished_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
